conf_reg_bank: RTL and testbench
================================

Name: conf_reg_bank

Overview:
Parametrised configuration register bank fed byte-wise from the RS232 receiver and read back byte-wise through the RS232 transmitter.
- Replaces fixed-size shift-in/shift-out register arrays with a framed protocol: header, command, payload, XOR checksum.
- Checksum-verified atomic commit of all registers; checksummed readback over a valid/ready transmit handshake.
- Inter-byte timeout abort.
- Sits between the UART byte interface and the signal-generator datapath (control, frequency and modulation-index registers).

Parameters:
N_BYTES, 11, number of configuration bytes (>=2); conf_regs byte k = bits [8k+7:8k]
HDR_BYTE, 8'hA5, frame start byte
TIMEOUT, 50000, max clk cycles between consecutive rx bytes inside a frame (>=2)

Ports:
clk  in  1  system clock, all logic on rising edge
rst_n  in  1  reset, asynchronous assert, active-low
rx_dw  in  8  received byte from RS232
rx_valid  in  1  one-cycle strobe, rx_dw valid
tx_dw  out  8  byte to RS232 transmitter
tx_valid  out  1  tx_dw valid
tx_ready  in  1  transmitter accepts tx_dw when tx_valid & tx_ready
conf_regs  out  8*N_BYTES  committed configuration, byte 0 in LSBs
conf_update  out  1  one-cycle pulse when conf_regs change
frame_err  out  1  one-cycle pulse on any aborted frame
busy  out  1  high in any state except IDLE

Behaviour:
Reset (rst_n low, asynchronous):
- conf_regs=0, tx_dw=0, tx_valid=0, conf_update=0, frame_err=0, busy=0.
- State=IDLE; counters and staging registers cleared.

Frame formats:
- Write: HDR, 8'h01, N_BYTES payload bytes (byte 0 first), CHK.
- Read: HDR, 8'h02, CHK.
- CHK = XOR of the CMD byte and all payload bytes.

FSM states: IDLE, CMD, PAYLOAD, CHK, TX, TX_CHK.
- IDLE: rx_valid & rx_dw==HDR_BYTE -> CMD. Other bytes are silently dropped, with no frame_err.
- CMD: 8'h01 -> PAYLOAD, byte index=0, running xor=8'h01. 8'h02 -> CHK, running xor=8'h02. Any other value -> frame_err pulse, then IDLE.
- PAYLOAD: each rx byte stored in staging[index]; xor updated; index increments. Last byte (index==N_BYTES-1) -> CHK.
- CHK, on a match:
  - Write frame: conf_regs loads staging on the same edge that samples the CHK byte; conf_update high the following cycle; -> IDLE.
  - Read frame: conf_regs snapshotted into the tx buffer on the same edge; -> TX.
- CHK, on a mismatch: frame_err pulse, conf_regs unchanged, -> IDLE.
- TX: tx_valid=1 and tx_dw=buffer[index], starting at index 0. On tx_valid & tx_ready, index increments. After byte N_BYTES-1 is accepted -> TX_CHK.
- TX_CHK: tx_dw = 8'h02 XOR all transmitted payload bytes, tx_valid=1. Accepted -> tx_valid=0, -> IDLE.

Timing:
- tx_dw and tx_valid are registered. The first readback byte is presented the cycle after the CHK edge.
- tx_dw is held stable while tx_valid & !tx_ready.

Timeout:
- Counter runs in CMD, PAYLOAD and CHK. It clears on every accepted rx byte.
- On reaching TIMEOUT cycles: frame_err pulse, staging discarded, -> IDLE.
- The counter does not run in TX or TX_CHK; the transmitter may stall indefinitely.

Boundary conditions:
- rx_valid during TX/TX_CHK: byte dropped, no error.
- HDR_BYTE appearing inside the payload is treated as data; there is no resync mid-frame.
- A timeout and an rx byte arriving on the same cycle: the byte wins, and the counter clears.
- rst_n asserted mid-frame or mid-readback: immediate return to the reset values. A partially received frame never reaches conf_regs.
- conf_update and frame_err never assert on the same cycle.

Test Plan:
1. N_BYTES=11. Send A5,01,01,02,...,0B,01 -> conf_regs=0x0B0A090807060504030201, one conf_update pulse, no frame_err.
2. After test 1, send A5,02,02 with tx_ready=1 -> tx bytes 01..0B then 02 (12 handshakes), busy low after the last accept.
3. Same write as test 1 with CHK=0x55 -> frame_err pulse on the cycle after CHK, conf_regs keeps its prior value, no conf_update.
4. Send A5,01 then 3 payload bytes, then idle for TIMEOUT cycles -> frame_err pulse, state IDLE. A following valid frame commits correctly.
5. Readback with tx_ready toggling 1,0,0,1 per cycle -> tx_dw stable while stalled, byte order 01..0B,02 preserved. Bytes injected on rx_valid during TX are ignored.
6. Bytes 00,FF,A5,7E before a frame -> 00/FF dropped, A5 starts a frame, 7E gives frame_err. Separately, drop rst_n mid-payload -> all outputs return to reset values immediately.

Source files
------------

// File: rtl/conf_reg_bank.sv
// conf_reg_bank: framed configuration register bank between the RS232 byte
// interface and the signal-generator datapath.
//
// A write frame (HDR, 01, N_BYTES payload bytes, CHK) commits all registers
// at once, and only when the XOR checksum matches. A read frame (HDR, 02, CHK)
// snapshots the registers and returns them byte-wise, followed by a checksum
// byte, over a valid/ready handshake. A gap between received bytes inside a
// frame longer than TIMEOUT cycles aborts the frame.
//
// Ports:
//   clk          system clock, rising edge
//   rst_n        asynchronous active-low reset
//   rx_dw        received byte
//   rx_valid     one-cycle strobe qualifying rx_dw
//   tx_dw        readback byte to the transmitter (registered)
//   tx_valid     tx_dw valid (registered)
//   tx_ready     transmitter accepts tx_dw when tx_valid & tx_ready
//   conf_regs    committed configuration, byte k at [8k+7:8k]
//   conf_update  one-cycle pulse after conf_regs changed
//   frame_err    one-cycle pulse for an aborted frame
//   busy         high whenever the controller is not idle
module conf_reg_bank #(
   parameter int unsigned N_BYTES  = 11,
   parameter logic [7:0]  HDR_BYTE = 8'hA5,
   parameter int unsigned TIMEOUT  = 50000
) (
   input  logic                   clk,
   input  logic                   rst_n,
   input  logic [7:0]             rx_dw,
   input  logic                   rx_valid,
   output logic [7:0]             tx_dw,
   output logic                   tx_valid,
   input  logic                   tx_ready,
   output logic [8*N_BYTES-1:0]   conf_regs,
   output logic                   conf_update,
   output logic                   frame_err,
   output logic                   busy
);

   localparam int unsigned IDX_W  = $clog2(N_BYTES);
   localparam int unsigned TCNT_W = (TIMEOUT > 2) ? $clog2(TIMEOUT) : 1;

   localparam logic [7:0]        CMD_WR    = 8'h01;
   localparam logic [7:0]        CMD_RD    = 8'h02;
   localparam logic [IDX_W-1:0]  LAST_IDX  = IDX_W'(N_BYTES - 1);
   localparam logic [TCNT_W-1:0] TCNT_LAST = TCNT_W'(TIMEOUT - 1);

   typedef enum logic [2:0] {
      S_IDLE,
      S_CMD,
      S_PAYLOAD,
      S_CHK,
      S_TX,
      S_TX_CHK
   } state_t;

   state_t             state;
   logic [IDX_W-1:0]   idx;
   logic [7:0]         xor_acc;
   logic               is_read;
   logic [TCNT_W-1:0]  tcnt;
   // staging doubles as the readback buffer; it is idle while transmitting
   logic [7:0]         staging [N_BYTES];
   logic [7:0]         conf_q  [N_BYTES];

   logic               in_rx;
   logic               timeout_hit;

   // Inter-byte timer only runs while a frame is being received
   assign in_rx       = (state == S_CMD) || (state == S_PAYLOAD) || (state == S_CHK);
   // A byte arriving on the expiry cycle wins over the timeout
   assign timeout_hit = in_rx && !rx_valid && (tcnt == TCNT_LAST);

   for (genvar g = 0; g < N_BYTES; g++) begin : g_pack
      assign conf_regs[8*g +: 8] = conf_q[g];
   end

   // Frame controller, register commit and readback
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state       <= S_IDLE;
         idx         <= '0;
         xor_acc     <= '0;
         is_read     <= 1'b0;
         tcnt        <= '0;
         staging     <= '{default: 8'h00};
         conf_q      <= '{default: 8'h00};
         tx_dw       <= '0;
         tx_valid    <= 1'b0;
         conf_update <= 1'b0;
         frame_err   <= 1'b0;
         busy        <= 1'b0;
      end else begin
         conf_update <= 1'b0;
         frame_err   <= 1'b0;
         tcnt        <= (in_rx && !rx_valid && !timeout_hit) ? tcnt + 1'b1 : '0;

         if (timeout_hit) begin
            state     <= S_IDLE;
            busy      <= 1'b0;
            frame_err <= 1'b1;
         end else begin
            case (state)
               S_IDLE: begin
                  if (rx_valid && (rx_dw == HDR_BYTE)) begin
                     state <= S_CMD;
                     busy  <= 1'b1;
                  end
               end

               S_CMD: begin
                  if (rx_valid) begin
                     if (rx_dw == CMD_WR) begin
                        state   <= S_PAYLOAD;
                        idx     <= '0;
                        xor_acc <= CMD_WR;
                        is_read <= 1'b0;
                     end else if (rx_dw == CMD_RD) begin
                        state   <= S_CHK;
                        xor_acc <= CMD_RD;
                        is_read <= 1'b1;
                     end else begin
                        state     <= S_IDLE;
                        busy      <= 1'b0;
                        frame_err <= 1'b1;
                     end
                  end
               end

               S_PAYLOAD: begin
                  if (rx_valid) begin
                     staging[idx] <= rx_dw;
                     xor_acc      <= xor_acc ^ rx_dw;
                     if (idx == LAST_IDX) begin
                        state <= S_CHK;
                     end else begin
                        idx <= idx + 1'b1;
                     end
                  end
               end

               S_CHK: begin
                  if (rx_valid) begin
                     if (rx_dw != xor_acc) begin
                        state     <= S_IDLE;
                        busy      <= 1'b0;
                        frame_err <= 1'b1;
                     end else if (!is_read) begin
                        conf_q      <= staging;
                        conf_update <= 1'b1;
                        state       <= S_IDLE;
                        busy        <= 1'b0;
                     end else begin
                        staging  <= conf_q;
                        tx_dw    <= conf_q[0];
                        tx_valid <= 1'b1;
                        idx      <= '0;
                        xor_acc  <= CMD_RD;
                        state    <= S_TX;
                     end
                  end
               end

               S_TX: begin
                  if (tx_ready) begin
                     xor_acc <= xor_acc ^ staging[idx];
                     if (idx == LAST_IDX) begin
                        tx_dw <= xor_acc ^ staging[idx];
                        state <= S_TX_CHK;
                     end else begin
                        tx_dw <= staging[idx + 1'b1];
                        idx   <= idx + 1'b1;
                     end
                  end
               end

               S_TX_CHK: begin
                  if (tx_ready) begin
                     tx_valid <= 1'b0;
                     state    <= S_IDLE;
                     busy     <= 1'b0;
                  end
               end

               default: begin
                  state    <= S_IDLE;
                  busy     <= 1'b0;
                  tx_valid <= 1'b0;
               end
            endcase
         end
      end
   end

endmodule

// File: tb/tb_conf_reg_bank.sv
// Bench for conf_reg_bank: table of whole frames with expected outcomes,
// hand-written readback/timeout/reset sequences and randomized frames
// checked against a frame-level model of the register bank.
module tb_conf_reg_bank;

   localparam int unsigned N   = 11;
   localparam int unsigned TO  = 40;
   localparam logic [7:0]  HDR = 8'hA5;

   logic             clk = 1'b0;
   logic             rst_n = 1'b0;
   logic [7:0]       rx_dw = 8'h00;
   logic             rx_valid = 1'b0;
   logic [7:0]       tx_dw;
   logic             tx_valid;
   logic             tx_ready = 1'b0;
   logic [8*N-1:0]   conf_regs;
   logic             conf_update;
   logic             frame_err;
   logic             busy;

   int checks = 0;
   int errors = 0;
   int n_upd  = 0;
   int n_err  = 0;

   logic [87:0] model_conf = '0;

   typedef struct packed {
      logic [15:0][7:0] b;
      logic [7:0]       len;
      logic             exp_upd;
      logic             exp_err;
      logic [87:0]      exp_regs;
   } vec_t;

   vec_t        vecs [7];
   logic [7:0]  q [$];

   conf_reg_bank #(
      .N_BYTES  (N),
      .HDR_BYTE (HDR),
      .TIMEOUT  (TO)
   ) dut (
      .clk         (clk),
      .rst_n       (rst_n),
      .rx_dw       (rx_dw),
      .rx_valid    (rx_valid),
      .tx_dw       (tx_dw),
      .tx_valid    (tx_valid),
      .tx_ready    (tx_ready),
      .conf_regs   (conf_regs),
      .conf_update (conf_update),
      .frame_err   (frame_err),
      .busy        (busy)
   );

   always #5 clk = ~clk;

   // Pulse counters; update and error must be mutually exclusive
   always @(negedge clk) begin
      if (conf_update) n_upd++;
      if (frame_err)   n_err++;
      if (conf_update && frame_err) begin
         checks++;
         errors++;
         $display("FAIL upd_err_exclusive both high at %0t", $time);
      end
   end

   initial begin
      #500000;
      $display("FAIL watchdog expired");
      $display("CHECKS %0d ERRORS %0d", checks, errors + 1);
      $fatal(1, "watchdog");
   end

   task automatic chk(input string name, input logic [87:0] act, input logic [87:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s actual=%0h expected=%0h", name, act, exp);
      end
   endtask

   // Called right after a negedge; returns at the negedge following the sampling edge
   task automatic send_byte(input logic [7:0] b);
      rx_dw    = b;
      rx_valid = 1'b1;
      @(negedge clk);
      rx_valid = 1'b0;
   endtask

   task automatic idle(input int n);
      repeat (n) @(negedge clk);
   endtask

   task automatic settle();
      repeat (3) @(negedge clk);
      #1;
   endtask

   function automatic vec_t mk(input logic [7:0] qq [$], input logic u, input logic e,
                               input logic [87:0] r);
      vec_t v;
      v = '0;
      foreach (qq[i]) v.b[i] = qq[i];
      v.len      = 8'(qq.size());
      v.exp_upd  = u;
      v.exp_err  = e;
      v.exp_regs = r;
      return v;
   endfunction

   task automatic write_frame(input logic [87:0] data, input logic [7:0] flip,
                              input int gap_pos, input int gap_len);
      logic [7:0] x;
      logic       good;
      int         u0, e0;
      x = 8'h01;
      for (int k = 0; k < int'(N); k++) x ^= data[8*k +: 8];
      good = (flip == 8'h00);
      u0 = n_upd;
      e0 = n_err;
      send_byte(HDR);
      send_byte(8'h01);
      for (int k = 0; k < int'(N); k++) begin
         if (k == gap_pos) idle(gap_len);
         send_byte(data[8*k +: 8]);
      end
      if (gap_pos == int'(N)) idle(gap_len);
      send_byte(x ^ flip);
      chk("wr_upd_pulse", 88'(conf_update), 88'(good));
      chk("wr_err_pulse", 88'(frame_err), 88'(!good));
      settle();
      if (good) model_conf = data;
      chk("wr_upd_count", 88'(n_upd - u0), 88'(good));
      chk("wr_err_count", 88'(n_err - e0), 88'(!good));
      chk("wr_regs", conf_regs, model_conf);
      chk("wr_busy", 88'(busy), 88'(0));
   endtask

   // mode 0: always ready, 1: ready pattern 1,0,0,1, 2: random ready
   task automatic read_frame(input int mode);
      logic [7:0] got [$];
      logic [7:0] held, xr;
      logic       held_v, rdy;
      int         cyc, u0, e0;
      u0 = n_upd;
      e0 = n_err;
      send_byte(HDR);
      send_byte(8'h02);
      send_byte(8'h02);
      chk("rd_first_valid", 88'(tx_valid), 88'(1));
      chk("rd_busy", 88'(busy), 88'(1));
      held_v = 1'b0;
      held   = 8'h00;
      cyc    = 0;
      while (got.size() < N + 1 && cyc < 600) begin
         if (held_v) chk("rd_stall_hold", 88'({tx_valid, tx_dw}), 88'({1'b1, held}));
         case (mode)
            0:       rdy = 1'b1;
            1:       rdy = ((cyc % 4) == 0) || ((cyc % 4) == 3);
            default: rdy = 1'($urandom_range(0, 1));
         endcase
         tx_ready = rdy;
         // a header byte during readback must be ignored
         rx_dw    = HDR;
         rx_valid = !rdy;
         if (tx_valid && rdy) begin
            got.push_back(tx_dw);
            held_v = 1'b0;
         end else if (tx_valid) begin
            held   = tx_dw;
            held_v = 1'b1;
         end
         @(negedge clk);
         cyc++;
      end
      tx_ready = 1'b0;
      rx_valid = 1'b0;
      chk("rd_handshakes", 88'(got.size()), 88'(N + 1));
      xr = 8'h02;
      for (int i = 0; i < int'(N); i++) begin
         xr ^= model_conf[8*i +: 8];
         if (i < got.size()) chk($sformatf("rd_byte%0d", i), 88'(got[i]), 88'(model_conf[8*i +: 8]));
      end
      if (got.size() > N) chk("rd_chk_byte", 88'(got[N]), 88'(xr));
      chk("rd_done_valid", 88'(tx_valid), 88'(0));
      chk("rd_done_busy", 88'(busy), 88'(0));
      #1;
      chk("rd_upd_count", 88'(n_upd - u0), 88'(0));
      chk("rd_err_count", 88'(n_err - e0), 88'(0));
      chk("rd_regs", conf_regs, model_conf);
   endtask

   // k=-1: header only; k>=0: header, write command and k payload bytes
   task automatic timeout_frame(input int k);
      send_byte(HDR);
      if (k >= 0) begin
         send_byte(8'h01);
         for (int i = 0; i < k; i++) send_byte(8'($urandom_range(0, 255)));
      end
      idle(int'(TO) - 1);
      chk("to_not_early", 88'(frame_err), 88'(0));
      chk("to_busy_before", 88'(busy), 88'(1));
      idle(1);
      chk("to_err_pulse", 88'(frame_err), 88'(1));
      chk("to_busy_after", 88'(busy), 88'(0));
      settle();
      chk("to_regs", conf_regs, model_conf);
   endtask

   task automatic bad_cmd_frame(input logic [7:0] c);
      int e0;
      e0 = n_err;
      send_byte(HDR);
      send_byte(c);
      chk("cmd_err_pulse", 88'(frame_err), 88'(1));
      settle();
      chk("cmd_err_count", 88'(n_err - e0), 88'(1));
      chk("cmd_regs", conf_regs, model_conf);
   endtask

   initial begin
      int          u0, e0, kind;
      logic [7:0]  b;
      logic [87:0] d;

      // reset state
      idle(3);
      chk("rst_regs", conf_regs, 88'(0));
      chk("rst_outs", 88'({tx_dw, tx_valid, conf_update, frame_err, busy}), 88'(0));
      rst_n = 1'b1;
      idle(2);

      // frame table
      q = {8'h00, 8'hFF, HDR, 8'h01};
      for (int k = 1; k <= 11; k++) q.push_back(8'(k));
      q.push_back(8'h01);
      vecs[0] = mk(q, 1'b1, 1'b0, 88'h0B0A090807060504030201);
      q = {HDR, 8'h01};
      for (int k = 1; k <= 11; k++) q.push_back(8'(k));
      q.push_back(8'h55);
      vecs[1] = mk(q, 1'b0, 1'b1, 88'h0B0A090807060504030201);
      q = {8'h00, 8'hFF, HDR, 8'h7E};
      vecs[2] = mk(q, 1'b0, 1'b1, 88'h0B0A090807060504030201);
      q = {HDR, 8'h01};
      for (int k = 0; k < 11; k++) q.push_back(HDR);
      q.push_back(8'hA4);
      vecs[3] = mk(q, 1'b1, 1'b0, {11{8'hA5}});
      q = {HDR, 8'h01};
      for (int k = 0; k < 11; k++) q.push_back(8'hF0 + 8'(k));
      q.push_back(8'hFA);
      vecs[4] = mk(q, 1'b1, 1'b0, 88'hFAF9F8F7F6F5F4F3F2F1F0);
      q = {HDR, 8'h03};
      vecs[5] = mk(q, 1'b0, 1'b1, 88'hFAF9F8F7F6F5F4F3F2F1F0);
      q = {HDR, 8'h02, 8'h03};
      vecs[6] = mk(q, 1'b0, 1'b1, 88'hFAF9F8F7F6F5F4F3F2F1F0);

      for (int i = 0; i < 7; i++) begin
         u0 = n_upd;
         e0 = n_err;
         for (int j = 0; j < int'(vecs[i].len); j++) send_byte(vecs[i].b[j]);
         chk($sformatf("vec%0d_upd_pulse", i), 88'(conf_update), 88'(vecs[i].exp_upd));
         chk($sformatf("vec%0d_err_pulse", i), 88'(frame_err), 88'(vecs[i].exp_err));
         settle();
         chk($sformatf("vec%0d_upd_count", i), 88'(n_upd - u0), 88'(vecs[i].exp_upd));
         chk($sformatf("vec%0d_err_count", i), 88'(n_err - e0), 88'(vecs[i].exp_err));
         chk($sformatf("vec%0d_regs", i), conf_regs, vecs[i].exp_regs);
         chk($sformatf("vec%0d_busy", i), 88'(busy), 88'(0));
         model_conf = vecs[i].exp_regs;
      end

      // readback: always ready, then stalling pattern
      read_frame(0);
      write_frame(88'h0B0A090807060504030201, 8'h00, -1, 0);
      read_frame(1);

      // timeout mid-payload, then a good frame
      timeout_frame(3);
      write_frame(88'h112233445566778899AABB, 8'h00, -1, 0);
      // byte arriving exactly on the expiry cycle is accepted
      write_frame(88'h0102030405060708090A0B, 8'h00, 5, int'(TO) - 1);
      write_frame(88'hCAFEF00D123456789ABCDE, 8'h00, int'(N), int'(TO) - 1);

      // randomized frames
      for (int it = 0; it < 30; it++) begin
         repeat ($urandom_range(0, 2)) begin
            b = 8'($urandom_range(0, 255));
            if (b == HDR) b = 8'h00;
            send_byte(b);
         end
         d    = 88'({$urandom(), $urandom(), $urandom()});
         kind = int'($urandom_range(0, 4));
         case (kind)
            0: write_frame(d, 8'h00, int'($urandom_range(0, N)), int'($urandom_range(0, TO - 1)));
            1: write_frame(d, 8'($urandom_range(1, 255)), -1, 0);
            2: read_frame(2);
            3: timeout_frame(int'($urandom_range(0, N + 1)) - 1);
            default: bad_cmd_frame(8'($urandom_range(3, 255)));
         endcase
      end

      // reset in the middle of a payload
      write_frame(88'h5A5A5A5A5A5A5A5A5A5A5A, 8'h00, -1, 0);
      u0 = n_upd;
      e0 = n_err;
      send_byte(HDR);
      send_byte(8'h01);
      for (int k = 1; k <= 4; k++) send_byte(8'(k));
      #2 rst_n = 1'b0;
      #1;
      chk("midrst_regs", conf_regs, 88'(0));
      chk("midrst_outs", 88'({tx_dw, tx_valid, conf_update, frame_err, busy}), 88'(0));
      @(negedge clk);
      rst_n = 1'b1;
      model_conf = '0;
      for (int k = 5; k <= 11; k++) send_byte(8'(k));
      send_byte(8'h01);
      settle();
      chk("midrst_partial_regs", conf_regs, 88'(0));
      chk("midrst_upd_count", 88'(n_upd - u0), 88'(0));
      chk("midrst_err_count", 88'(n_err - e0), 88'(0));

      // reset in the middle of a stalled readback
      write_frame(88'h0B0A090807060504030201, 8'h00, -1, 0);
      tx_ready = 1'b0;
      send_byte(HDR);
      send_byte(8'h02);
      send_byte(8'h02);
      idle(3);
      chk("rdrst_valid_before", 88'({tx_valid, tx_dw}), 88'({1'b1, 8'h01}));
      #2 rst_n = 1'b0;
      #1;
      chk("rdrst_outs", 88'({tx_dw, tx_valid, conf_update, frame_err, busy}), 88'(0));
      chk("rdrst_regs", conf_regs, 88'(0));
      @(negedge clk);
      rst_n = 1'b1;
      model_conf = '0;
      idle(2);

      // recovery after reset
      write_frame(88'h00FF00FF00FF00FF00FF00, 8'h00, -1, 0);
      read_frame(0);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
